// File: rtl/comparator_seq_pkg.sv
// -----------------------------------------------------------------------------
// comparator_seq_pkg
//  Shared definitions for the multi-cycle compare unit:
//   - compare mode codes (COM_EQ .. COM_GEU, 6-7 reserved)
//   - FSM state encoding (S_IDLE, S_RUN, S_DONE)
//   - helpers that decode a mode into its signedness and its final truth value
// -----------------------------------------------------------------------------
package comparator_seq_pkg;

    localparam logic [2:0] COM_EQ  = 3'd0;
    localparam logic [2:0] COM_NE  = 3'd1;
    localparam logic [2:0] COM_LT  = 3'd2;
    localparam logic [2:0] COM_GE  = 3'd3;
    localparam logic [2:0] COM_LTU = 3'd4;
    localparam logic [2:0] COM_GEU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Only the two signed magnitude modes need the sign-bit flip on the top chunk.
    function automatic logic is_signed_mode(input logic [2:0] mode);
        logic res;
        case (mode)
            COM_LT:  res = 1'b1;
            COM_GE:  res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Map the two comparison flags to the truth value of the requested mode.
    function automatic logic mode_result(input logic [2:0] mode,
                                         input logic       igual,
                                         input logic       menor);
        logic res;
        case (mode)
            COM_EQ:  res = igual;
            COM_NE:  res = ~igual;
            COM_LT:  res = menor;
            COM_GE:  res = ~menor;
            COM_LTU: res = menor;
            COM_GEU: res = ~menor;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/comparator_seq_cmp_chunk.sv
// -----------------------------------------------------------------------------
// cmp_chunk
//  Combinational compare of one CHUNK-bit slice of the operands.
//  Ports:
//   i_a, i_b      CHUNK-bit slices of operand A and B
//   i_invert_msb  flip the top bit of both slices (two's-complement ordering
//                 on the most significant chunk)
//   o_eq          slices are equal
//   o_lt          slice A < slice B (unsigned, after optional MSB flip)
// -----------------------------------------------------------------------------
module cmp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_invert_msb,
    output logic             o_eq,
    output logic             o_lt
);

    logic [CHUNK-1:0] w_mask;
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;

    // Build the sign-flip mask and the adjusted slices.
    always_comb begin
        w_mask            = {CHUNK{1'b0}};
        w_mask[CHUNK-1]   = i_invert_msb;
        w_a               = i_a ^ w_mask;
        w_b               = i_b ^ w_mask;
    end

    // Equality is unaffected by the flip; less-than uses the adjusted slices.
    always_comb begin
        o_eq = (w_a == w_b);
        o_lt = (w_a < w_b);
    end

endmodule

// File: rtl/comparator_seq.sv
// -----------------------------------------------------------------------------
// comparator_seq
//  Shared multi-cycle compare unit. Compares two WIDTH-bit operands CHUNK bits
//  per cycle, most significant chunk first, stopping on the first chunk that
//  differs. Supports EQ/NE and signed/unsigned LT/GE modes.
//  Ports:
//   I_CLK, I_RST_N   clock (rising edge), asynchronous active-low reset
//   I_COM_START      request, accepted only while idle
//   I_COM_MODE       0 EQ, 1 NE, 2 LT, 3 GE, 4 LTU, 5 GEU, 6-7 reserved
//   I_COM_A/B        operands, latched at acceptance
//   O_COM_BUSY       high while a compare is in flight or completing
//   O_COM_DONE       one-cycle pulse, result flags valid
//   O_COM_RESULT     mode-dependent truth value
//   O_COM_IGUAL      A == B
//   O_COM_MENOR      A < B under the mode's signedness (EQ/NE: unsigned)
// -----------------------------------------------------------------------------
module comparator_seq
    import comparator_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             I_CLK,
    input  logic             I_RST_N,
    input  logic             I_COM_START,
    input  logic [2:0]       I_COM_MODE,
    input  logic [WIDTH-1:0] I_COM_A,
    input  logic [WIDTH-1:0] I_COM_B,
    output logic             O_COM_BUSY,
    output logic             O_COM_DONE,
    output logic             O_COM_RESULT,
    output logic             O_COM_IGUAL,
    output logic             O_COM_MENOR
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP  = IDXW'(NCHUNK - 1);
    localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
            $error("comparator_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t                       r_state;
    state_t                       w_next_state;
    logic [IDXW-1:0]              r_idx;
    logic [NCHUNK-1:0][CHUNK-1:0] r_a;
    logic [NCHUNK-1:0][CHUNK-1:0] r_b;
    logic [2:0]                   r_mode;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_result;
    logic                         r_igual;
    logic                         r_menor;

    logic [CHUNK-1:0]             w_a_chunk;
    logic [CHUNK-1:0]             w_b_chunk;
    logic                         w_invert_msb;
    logic                         w_chunk_eq;
    logic                         w_chunk_lt;

    // Select the chunk under examination; the sign flip applies only to the top chunk.
    always_comb begin
        w_a_chunk    = r_a[r_idx];
        w_b_chunk    = r_b[r_idx];
        w_invert_msb = is_signed_mode(r_mode) && (r_idx == IDX_TOP);
    end

    cmp_chunk #(
        .CHUNK (CHUNK)
    ) u_cmp_chunk (
        .i_a          (w_a_chunk),
        .i_b          (w_b_chunk),
        .i_invert_msb (w_invert_msb),
        .o_eq         (w_chunk_eq),
        .o_lt         (w_chunk_lt)
    );

    // FSM state register.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic: exit RUN on the first differing chunk or after chunk 0.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (I_COM_START) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (!w_chunk_eq || (r_idx == IDX_ZERO)) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake outputs, registered from the next state so they align with r_state.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next_state != S_IDLE);
            r_done <= (w_next_state == S_DONE);
        end
    end

    // Operand capture, chunk index walk and result flags.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_mode   <= 3'd0;
            r_idx    <= IDX_ZERO;
            r_result <= 1'b0;
            r_igual  <= 1'b0;
            r_menor  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (I_COM_START) begin
                        r_a      <= I_COM_A;
                        r_b      <= I_COM_B;
                        r_mode   <= I_COM_MODE;
                        r_idx    <= IDX_TOP;
                        // Previous flags are dropped as soon as a new compare begins.
                        r_result <= 1'b0;
                        r_igual  <= 1'b0;
                        r_menor  <= 1'b0;
                    end else begin
                        r_idx <= r_idx;
                    end
                end
                S_RUN: begin
                    if (!w_chunk_eq) begin
                        r_igual  <= 1'b0;
                        r_menor  <= w_chunk_lt;
                        r_result <= mode_result(r_mode, 1'b0, w_chunk_lt);
                    end else if (r_idx == IDX_ZERO) begin
                        r_igual  <= 1'b1;
                        r_menor  <= 1'b0;
                        r_result <= mode_result(r_mode, 1'b1, 1'b0);
                    end else begin
                        r_idx <= r_idx - IDX_ONE;
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign O_COM_BUSY   = r_busy;
    assign O_COM_DONE   = r_done;
    assign O_COM_RESULT = r_result;
    assign O_COM_IGUAL  = r_igual;
    assign O_COM_MENOR  = r_menor;

endmodule

// File: tb/tb_comparator_seq.sv
module tb_comparator_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        result;
    logic        igual;
    logic        menor;

    int total = 0;
    int bad   = 0;

    comparator_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .I_CLK        (clk),
        .I_RST_N      (rst_n),
        .I_COM_START  (start),
        .I_COM_MODE   (mode),
        .I_COM_A      (a),
        .I_COM_B      (b),
        .O_COM_BUSY   (busy),
        .O_COM_DONE   (done),
        .O_COM_RESULT (result),
        .O_COM_IGUAL  (igual),
        .O_COM_MENOR  (menor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: number of byte chunks examined, MSB first, until one differs.
    function automatic int ref_chunks(input logic [31:0] x, input logic [31:0] y);
        for (int i = 3; i >= 0; i--) begin
            if (((x >> (8 * i)) & 32'hFF) != ((y >> (8 * i)) & 32'hFF)) return 4 - i;
        end
        return 4;
    endfunction

    function automatic logic ref_menor(input logic [2:0] m, input logic [31:0] x, input logic [31:0] y);
        if (m == 3'd2 || m == 3'd3) return ($signed(x) < $signed(y));
        return (x < y);
    endfunction

    function automatic logic ref_result(input logic [2:0] m, input logic [31:0] x, input logic [31:0] y);
        case (m)
            3'd0: return (x == y);
            3'd1: return (x != y);
            3'd2: return ($signed(x) < $signed(y));
            3'd3: return ($signed(x) >= $signed(y));
            3'd4: return (x < y);
            3'd5: return (x >= y);
            default: return 1'b0;
        endcase
    endfunction

    // One complete transaction. poke_run: pulse START with other operands during RUN.
    // restart_in_done: assert START in the DONE cycle and check it is ignored.
    task automatic run_txn(input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] tm,
                           input bit poke_run, input bit restart_in_done, input string tag);
        int  cyc;
        bit  seen;
        logic e_ig, e_mn, e_rs;
        e_ig = (ta == tb_);
        e_mn = ref_menor(tm, ta, tb_);
        e_rs = ref_result(tm, ta, tb_);
        @(negedge clk);
        a = ta; b = tb_; mode = tm; start = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_on_run"}, 32'(busy), 32'd1);
        check({tag, " flags_cleared"}, {29'd0, result, igual, menor}, 32'd0);
        if (poke_run) begin
            start = 1'b1; a = ~ta; b = ta ^ 32'h5A5A0000; mode = tm ^ 3'd1;
        end
        seen = done;
        while (!seen && cyc < 12) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (poke_run) start = 1'b0;
            seen = done;
            if (!seen && poke_run) check({tag, " busy_unbroken"}, 32'(busy), 32'd1);
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(ref_chunks(ta, tb_) + 1));
        check({tag, " igual"}, 32'(igual), 32'(e_ig));
        check({tag, " menor"}, 32'(menor), 32'(e_mn));
        check({tag, " result"}, 32'(result), 32'(e_rs));
        if (restart_in_done) begin
            start = 1'b1; a = 32'h12345678; b = 32'h12345679; mode = 3'd1;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, " idle_after_done"}, {30'd0, busy, done}, 32'd0);
        check({tag, " flags_hold"}, {29'd0, result, igual, menor}, {29'd0, e_rs, e_ig, e_mn});
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rm;
        int          cnt_done;
        rst_n = 1'b0; start = 1'b0; mode = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {27'd0, busy, done, result, igual, menor}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", {27'd0, busy, done, result, igual, menor}, 32'd0);

        // Directed cases.
        run_txn(32'd255, 32'd0, 3'd0, 1'b0, 1'b0, "eq_255_0");
        run_txn(32'h00AA1155, 32'h00AA1155, 3'd0, 1'b0, 1'b0, "eq_same");
        run_txn(32'h00AA1155, 32'h00AA1155, 3'd1, 1'b0, 1'b1, "ne_same");
        run_txn(32'hFFFFFFFF, 32'h00000001, 3'd2, 1'b0, 1'b0, "lt_neg1");
        run_txn(32'hFFFFFFFF, 32'h00000001, 3'd4, 1'b0, 1'b0, "ltu_max");
        run_txn(32'h0000FF3C, 32'hFFFFFFFF, 3'd5, 1'b0, 1'b0, "geu_chunk3");
        run_txn(32'h80000000, 32'h7FFFFFFF, 3'd3, 1'b0, 1'b0, "ge_minint");
        run_txn(32'h01020304, 32'h01020305, 3'd6, 1'b0, 1'b0, "reserved6");
        run_txn(32'h00000010, 32'h00000100, 3'd4, 1'b1, 1'b1, "poke_run");

        // Reset in the second RUN cycle aborts with no DONE pulse.
        @(negedge clk);
        a = 32'hCAFEBABE; b = 32'hCAFEBABE; mode = 3'd0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {27'd0, busy, done, result, igual, menor}, 32'd0);
        cnt_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) cnt_done++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) cnt_done++;
        end
        check("abort_no_done", 32'(cnt_done), 32'd0);
        run_txn(32'hCAFEBABE, 32'hCAFEBABE, 3'd0, 1'b0, 1'b0, "after_abort");

        // Randomized transactions; operands often share high chunks to vary exit depth.
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            rm = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = {ra[31:16], rb[15:0]};
                2: rb = {ra[31:8], rb[7:0]};
                default: rb = rb;
            endcase
            run_txn(ra, rb, rm, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
